// File: rtl/a1_scaler_pkg.sv
// Shared constants for the a1_scaler timing front end: default scaler width
// and the sc[1:0] codes that mark the stage-2 phase-A and phase-B pulses.
package a1_pkg;

  localparam int STAGES_DEFAULT = 16;

  localparam logic [1:0] PH_A = 2'b01;
  localparam logic [1:0] PH_B = 2'b11;

endpackage : a1_pkg

// File: rtl/a1_phase_decode.sv
// Stage-2 phase decode: turns the next scaler value's two low bits into the
// next-state values of the one-clock F02A / F02B pulses.
module a1_phase_decode
  import a1_pkg::*;
(
  input  logic [1:0] sc_next_i,
  output logic       f02a_d_o,
  output logic       f02b_d_o
);

  // Both codes have bit 0 set, so either pulse implies FS02 high.
  assign f02a_d_o = (sc_next_i == PH_A);
  assign f02b_d_o = (sc_next_i == PH_B);

endmodule : a1_phase_decode

// File: rtl/a1_scaler.sv
// Timing scaler front end: free-running STAGES-bit binary scaler clocked by
// FS01_, with registered stage-2 outputs. Optional tap port: A1_SCALER_TAP_EN.
module a1_scaler
  import a1_pkg::*;
#(
  parameter int STAGES = STAGES_DEFAULT
) (
  input  logic              rst,
  input  logic              FS01_,
  output logic              F02B,
  output logic              FS02,
  output logic              F02A,
  output logic              FS02A
`ifdef A1_SCALER_TAP_EN
  ,
  output logic [STAGES-1:0] FS_TAP
`endif
);

  // Declared initial values keep every output defined even without a reset.
  logic [STAGES-1:0] sc_q    = '0;
  logic              fs02_q  = 1'b0;
  logic              fs02a_q = 1'b0;
  logic              f02a_q  = 1'b0;
  logic              f02b_q  = 1'b0;

  logic [STAGES-1:0] sc_d;
  logic              f02a_d;
  logic              f02b_d;

  // Natural modulo-2^STAGES wrap of the adder gives the required rollover.
  assign sc_d = sc_q + {{(STAGES-1){1'b0}}, 1'b1};

  a1_phase_decode u_phase_decode (
    .sc_next_i (sc_d[1:0]),
    .f02a_d_o  (f02a_d),
    .f02b_d_o  (f02b_d)
  );

  always_ff @(posedge FS01_) begin
    if (rst) begin
      sc_q    <= '0;
      fs02_q  <= 1'b0;
      fs02a_q <= 1'b0;
      f02a_q  <= 1'b0;
      f02b_q  <= 1'b0;
    end else begin
      sc_q    <= sc_d;
      fs02_q  <= sc_d[0];
      fs02a_q <= sc_d[0];
      f02a_q  <= f02a_d;
      f02b_q  <= f02b_d;
    end
  end

  assign FS02  = fs02_q;
  assign FS02A = fs02a_q;
  assign F02A  = f02a_q;
  assign F02B  = f02b_q;

`ifdef A1_SCALER_TAP_EN
  // The counter register itself is the registered tap; it resets with sc.
  assign FS_TAP = sc_q;
`endif

endmodule : a1_scaler

// File: tb/tb_a1_scaler.sv
// Scoreboard bench for a1_scaler: the driver pushes hand-tabled stage-2
// expectations per edge, a monitor pops and compares after each rising edge.
module tb_a1_scaler;

  typedef struct packed {
    logic        fs02;
    logic        f02a;
    logic        f02b;
    logic        win;
    logic [31:0] cnt;
  } exp_t;

  logic FS01_ = 1'b0;
  logic rst   = 1'b0;

  logic f02b_w, fs02_w, f02a_w, fs02a_w;
  logic f02b_w2, fs02_w2, f02a_w2, fs02a_w2;
`ifdef A1_SCALER_TAP_EN
  logic [15:0] tap_w;
  logic [3:0]  tap_w4;
`endif

  a1_scaler #(.STAGES(16)) u_dut (
    .rst   (rst),
    .FS01_ (FS01_),
    .F02B  (f02b_w),
    .FS02  (fs02_w),
    .F02A  (f02a_w),
    .FS02A (fs02a_w)
`ifdef A1_SCALER_TAP_EN
    ,
    .FS_TAP(tap_w)
`endif
  );

  // Narrow instance: wraps every 4 edges, exercising the 3->0 rollover.
`ifdef A1_SCALER_TAP_EN
  a1_scaler #(.STAGES(4)) u_dut_s4 (
    .rst   (rst),
    .FS01_ (FS01_),
    .F02B  (f02b_w2),
    .FS02  (fs02_w2),
    .F02A  (f02a_w2),
    .FS02A (fs02a_w2),
    .FS_TAP(tap_w4)
  );
`else
  a1_scaler #(.STAGES(2)) u_dut_s2 (
    .rst   (rst),
    .FS01_ (FS01_),
    .F02B  (f02b_w2),
    .FS02  (fs02_w2),
    .F02A  (f02a_w2),
    .FS02A (fs02a_w2)
  );
`endif

  // ---------------- clock ----------------
  initial forever #5 FS01_ = ~FS01_;

  // ---------------- scoreboard state ----------------
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   k        = 0;
  logic win      = 1'b0;
  int   cnt_a    = 0;
  int   cnt_b    = 0;
  // Indexed by edges-since-reset mod 4: {FS02, F02A, F02B}
  logic [2:0] tbl [4] = '{3'b000, 3'b110, 3'b000, 3'b101};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge: drive rst, predict the outputs that edge produces.
  task automatic step(input logic r);
    exp_t e;
    rst = r;
    if (r) k = 0;
    else   k = k + 1;
    e.fs02 = r ? 1'b0 : tbl[k % 4][2];
    e.f02a = r ? 1'b0 : tbl[k % 4][1];
    e.f02b = r ? 1'b0 : tbl[k % 4][0];
    e.win  = win;
    e.cnt  = k;
    exp_q.push_back(e);
    @(negedge FS01_);
  endtask

  // ---------------- monitor ----------------
  always @(posedge FS01_) begin
    exp_t e;
    #1;
    if (exp_q.size() == 0) begin
      check("unexpected_edge", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("fs02",  {31'd0, fs02_w},  {31'd0, e.fs02});
      check("fs02a", {31'd0, fs02a_w}, {31'd0, e.fs02});
      check("f02a",  {31'd0, f02a_w},  {31'd0, e.f02a});
      check("f02b",  {31'd0, f02b_w},  {31'd0, e.f02b});
      check("f02a_and_f02b", {31'd0, f02a_w & f02b_w}, 32'd0);
      check("pulse_without_fs02", {31'd0, (f02a_w | f02b_w) & ~fs02_w}, 32'd0);
      check("narrow_fs02",  {31'd0, fs02_w2},  {31'd0, e.fs02});
      check("narrow_fs02a", {31'd0, fs02a_w2}, {31'd0, e.fs02});
      check("narrow_f02a",  {31'd0, f02a_w2},  {31'd0, e.f02a});
      check("narrow_f02b",  {31'd0, f02b_w2},  {31'd0, e.f02b});
`ifdef A1_SCALER_TAP_EN
      check("fs_tap16", {16'd0, tap_w},  e.cnt & 32'hFFFF);
      check("fs_tap4",  {28'd0, tap_w4}, e.cnt & 32'hF);
`endif
      if (e.win) begin
        if (f02a_w) cnt_a++;
        if (f02b_w) cnt_b++;
      end
    end
  end

  // ---------------- driver ----------------
  initial begin
    #1;
    // Power-up, no reset: declared initial values, never X.
    check("pwr_fs02",  {31'd0, fs02_w},  32'd0);
    check("pwr_fs02a", {31'd0, fs02a_w}, 32'd0);
    check("pwr_f02a",  {31'd0, f02a_w},  32'd0);
    check("pwr_f02b",  {31'd0, f02b_w},  32'd0);
    check("pwr_known", {31'd0, $isunknown({fs02_w, fs02a_w, f02a_w, f02b_w,
                                           fs02_w2, fs02a_w2, f02a_w2, f02b_w2})}, 32'd0);

    for (int i = 0; i < 3; i++) step(1'b0);

    // Two reset edges, then the post-reset pattern.
    step(1'b1);
    step(1'b1);
    for (int i = 0; i < 4; i++) step(1'b0);

    // 64 free-running edges inside the pulse-count window.
    win = 1'b1;
    for (int i = 0; i < 64; i++) step(1'b0);
    win = 1'b0;

    // Reset while sc[1:0] == 2'b10, then F02A on the first free edge.
    for (int i = 0; i < 4 && (k % 4) != 2; i++) step(1'b0);
    check("mid_reset_phase", k % 4, 32'd2);
    step(1'b1);
    for (int i = 0; i < 18; i++) step(1'b0);

    // Drain: one more edge lets the monitor consume the last entry.
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(posedge FS01_);
    #2;
    check("queue_drained", exp_q.size(), 32'd0);
    check("f02a_count", cnt_a, 32'd16);
    check("f02b_count", cnt_b, 32'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_a1_scaler
